hs_fifo: RTL
============

HS_FIFO -- requirements
Module: hs_fifo

Interface
REQ-001 Parameter WIDTH, default 3: data word width in bits; matches the 3-bit result word produced upstream.
REQ-002 Parameter DEPTH, default 4: number of storage entries; legal values are powers of two, at least 2.
REQ-003 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  upstream presents a word on in_data.
REQ-006 in_ready  output  1  FIFO can accept a word this cycle.
REQ-007 in_data  input  WIDTH  write data.
REQ-008 out_valid  output  1  out_data holds the oldest stored word.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  WIDTH  read data (first-word fall-through).
REQ-011 count  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 stall_cnt  output  16  upstream stall-cycle counter; this port exists only when HS_FIFO_STALL_CNT_EN is defined.

Function
REQ-015 Push occurs on a rising edge where in_valid && in_ready; push writes in_data at wr_ptr, then advances wr_ptr modulo DEPTH.
REQ-016 Pop occurs on a rising edge where out_valid && out_ready; pop advances rd_ptr modulo DEPTH.
REQ-017 in_ready = !full && !rst, registered or derived from registered state only; no combinational path from out_ready to in_ready.
REQ-018 out_valid = !empty; out_data = mem[rd_ptr]; no combinational path from in_valid or in_data to out_valid or out_data.
REQ-019 Latency: a word pushed into an empty FIFO at edge N appears with out_valid = 1 in the cycle following edge N.
REQ-020 Simultaneous push and pop leaves count unchanged and moves both pointers.
REQ-021 Push only increments count by 1; pop only decrements count by 1.
REQ-022 When full, in_ready = 0 and in_valid has no effect; a pop while full sets in_ready = 1 in the next cycle.
REQ-023 When empty, out_valid = 0 and out_ready has no effect; count never underflows.
REQ-024 While out_valid && !out_ready, out_data and out_valid remain stable until the pop occurs.
REQ-025 Words leave in exactly the order they entered, with no loss or duplication, across pointer wrap-around.
REQ-026 Pointers are log2(DEPTH)+1 bits; full and empty are derived from pointer equality and the MSB difference, and agree with count.

Reset
REQ-027 While rst = 1 at a rising edge, the block sets wr_ptr = 0, rd_ptr = 0 and count = 0.
REQ-028 Output values while in reset: empty = 1, full = 0, out_valid = 0, in_ready = 0; stall_cnt = 0 when the counter is present.
REQ-029 Asserting rst mid-operation discards all stored words; the block does not clear memory contents; in the first cycle after rst deasserts, in_ready = 1.

Configuration
REQ-030 Macro HS_FIFO_STALL_CNT_EN controls the stall counter.
REQ-031 Defined: stall_cnt increments on each edge where in_valid && !in_ready && !rst, and saturates at 16'hFFFF.
REQ-032 Not defined: the stall_cnt port and its logic are absent, and all other behaviour is identical.

Verification
REQ-033 Reset: hold rst = 1 for 2 cycles with in_valid = 1 -> count = 0, empty = 1, in_ready = 0, out_valid = 0; in the first cycle after release, in_ready = 1.
REQ-034 Fill/drain: out_ready = 0, push 3'd1..3'd4 on consecutive cycles -> full = 1, count = 4, in_ready = 0; then out_ready = 1 -> outputs 1,2,3,4 on 4 consecutive cycles, ending with empty = 1.
REQ-035 Streaming: in_valid = out_ready = 1 for 20 cycles with an incrementing 3-bit pattern (wraps 7 -> 0) -> count stays at 1 after the first word, and the output sequence equals the input sequence delayed 1 cycle.
REQ-036 Full with simultaneous push and pop: at count = 4, in_valid = out_ready = 1 -> pop occurs, push is refused (in_ready = 0), count = 3 next cycle; the word held on in_data is accepted the cycle after.
REQ-037 Mid-operation reset: with count = 3, pulse rst for 1 cycle -> count = 0, out_valid = 0; a subsequent push of 3'd5 is output as 3'd5 with no stale data.
REQ-038 Stall counter (macro defined): with full held and in_valid = 1 for 10 cycles -> stall_cnt = 10; with the counter preloaded near saturation in simulation, stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/hs_fifo.sv
// ---------------------------------------------------------------------------
// hs_fifo -- synchronous first-word fall-through FIFO with valid/ready ports.
//
// Optional feature macro: HS_FIFO_STALL_CNT_EN
//   When defined, the 16-bit saturating upstream stall counter and its
//   stall_cnt port are built. When undefined, both are absent and the rest
//   of the block behaves identically.
//
// Parameters
//   WIDTH  data word width in bits
//   DEPTH  number of storage entries (power of two, >= 2)
//
// Ports
//   sys_clk    in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   upstream presents a word on in_data
//   in_ready   out  FIFO can accept a word this cycle
//   in_data    in   write data
//   out_valid  out  out_data holds the oldest stored word
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  read data (first-word fall-through)
//   count      out  number of stored entries, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
//   stall_cnt  out  upstream stall cycles, saturating (macro builds only)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side. in_ready depends only on registered state and rst,
// and out_valid/out_data depend only on registered state, so neither side
// sees a combinational path from the other side's inputs. Once out_valid is
// high, out_valid and out_data hold until the word is popped.
// ---------------------------------------------------------------------------
module hs_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
`ifdef HS_FIFO_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic ptr_full, ptr_empty;
    logic push, pop;

    // The extra pointer MSB tells a full buffer (same index, opposite lap)
    // from an empty one (identical pointers).
    assign ptr_empty = (wr_ptr_q == rd_ptr_q);
    assign ptr_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Gate the flags with rst so the port values are the reset values for
    // the whole time rst is high, including the cycle before its first edge.
    assign in_ready  = !ptr_full && !rst;
    assign full      = ptr_full && !rst;
    assign empty     = ptr_empty || rst;
    assign out_valid = !ptr_empty && !rst;
    assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + PW'(1);
        end else if (pop && !push) begin
            count_d = count_q - PW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not cleared by reset; the pointers alone
    // decide which entries are live.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

`ifdef HS_FIFO_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // A stall is an offered word that is refused outside reset.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
